// File: rtl/fp_add_normalize.sv
// fp_add_normalize -- multi-cycle add/normalize/round back end of a
// single-precision adder. Operands arrive already aligned to a common
// exponent; the block adds or subtracts the magnitudes, normalizes with
// one shift per cycle, rounds to nearest-even and packs an IEEE-754 word.
//
// Ports:
//   clk, res            clock, synchronous active-high reset
//   in_a, in_b          27-bit aligned operands {sign, hidden, frac[22:0], guard, sticky}
//   in_exp              common biased exponent
//   in_valid/in_ready   operand handshake (ready only while idle)
//   out_result          packed single-precision result
//   out_valid/out_ready result handshake; result and flags held until taken
//   out_zero, out_ovf   exact/flushed zero, overflow to infinity
module fp_add_normalize (
  input  logic        clk,
  input  logic        res,
  input  logic [26:0] in_a,
  input  logic [26:0] in_b,
  input  logic [7:0]  in_exp,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_zero,
  output logic        out_ovf
);

  typedef enum logic [2:0] {S_IDLE, S_ADD, S_NORM, S_ROUND, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [26:0] a_q, a_d, b_q, b_d;
  logic [26:0] mant_q, mant_d;
  logic        sign_q, sign_d;
  logic [9:0]  exp_q, exp_d;     // headroom for +1 in NORM and +1 in ROUND
  logic        pad_q, pad_d;
  logic [31:0] result_q, result_d;
  logic        zero_q, zero_d;
  logic        ovf_q, ovf_d;

  // Magnitude add/subtract of the captured operands.
  logic [26:0] mag_a, mag_b, sum_mag;
  logic        sum_sign;

  always_comb begin
    mag_a = {1'b0, a_q[25:0]};
    mag_b = {1'b0, b_q[25:0]};
    if (a_q[26] == b_q[26]) begin
      sum_mag  = mag_a + mag_b;
      sum_sign = a_q[26];
    end else if (mag_a > mag_b) begin
      sum_mag  = mag_a - mag_b;
      sum_sign = a_q[26];
    end else if (mag_b > mag_a) begin
      sum_mag  = mag_b - mag_a;
      sum_sign = b_q[26];
    end else begin
      sum_mag  = '0;           // cancellation is always +0
      sum_sign = 1'b0;
    end
  end

  // Round-to-nearest-even on the normalized mantissa (bit 25 set).
  logic        rnd_inc;
  logic [24:0] rnd;
  logic [9:0]  exp_rnd;
  logic [22:0] frac_rnd;

  always_comb begin
    rnd_inc  = mant_q[1] & (mant_q[0] | mant_q[2]);
    rnd      = {1'b0, mant_q[25:2]} + {24'd0, rnd_inc};
    // carry out of the hidden bit renormalizes by one right shift
    exp_rnd  = exp_q + {9'd0, rnd[24]};
    frac_rnd = rnd[24] ? rnd[23:1] : rnd[22:0];
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    mant_d   = mant_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    pad_d    = pad_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          exp_d   = {2'b00, in_exp};
          pad_d   = 1'b0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        mant_d = sum_mag;
        sign_d = sum_sign;
        if (sum_mag == '0) begin
          // Zero result spends two cycles in ADD so its latency is a fixed 2.
          if (pad_q) begin
            result_d = 32'h0000_0000;
            zero_d   = 1'b1;
            state_d  = S_DONE;
          end else begin
            pad_d = 1'b1;
          end
        end else begin
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        if (mant_q[26]) begin
          mant_d = {1'b0, mant_q[26:2], mant_q[1] | mant_q[0]};
          exp_d  = exp_q + 10'd1;
        end else if (!mant_q[25]) begin
          if (exp_q <= 10'd1) begin
            // no denormals: flush to signed zero
            result_d = {sign_q, 31'd0};
            zero_d   = 1'b1;
            state_d  = S_DONE;
          end else begin
            mant_d = {mant_q[25:0], 1'b0};
            exp_d  = exp_q - 10'd1;
          end
        end else begin
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        if (exp_rnd >= 10'd255) begin
          result_d = {sign_q, 8'hFF, 23'd0};
          ovf_d    = 1'b1;
        end else begin
          result_d = {sign_q, exp_rnd[7:0], frac_rnd};
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          result_d = 32'h0000_0000;
          zero_d   = 1'b0;
          ovf_d    = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      mant_q   <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      pad_q    <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mant_q   <= mant_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      pad_q    <= pad_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign out_result = result_q;
  assign out_zero   = zero_q;
  assign out_ovf    = ovf_q;

endmodule

// File: doc/fp_add_normalize.md
FP_ADD_NORMALIZE -- requirements
Module: fp_add_normalize

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports as listed here.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 res  input  1  synchronous active-high reset.
REQ-004 in_a  input  27  aligned operand A: [26] sign, [25] hidden 1, [24:2] fraction, [1:0] guard/sticky.
REQ-005 in_b  input  27  aligned operand B, same format, already right-shifted to the common exponent.
REQ-006 in_exp  input  8  common (larger) biased exponent of both operands.
REQ-007 in_valid  input  1  operand set valid.
REQ-008 in_ready  output  1  block can accept an operand set.
REQ-009 out_result  output  32  IEEE-754 single result: [31] sign, [30:23] exponent, [22:0] fraction.
REQ-010 out_valid  output  1  out_result and flags valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 out_zero  output  1  result is exact zero or flushed to zero.
REQ-013 out_ovf  output  1  result overflowed to infinity.

Function
REQ-014 The FSM SHALL have states IDLE, ADD, NORM, ROUND and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; an operand set is accepted on a clock edge with in_valid=1 in IDLE, which captures in_a, in_b and in_exp and enters ADD.
REQ-016 ADD SHALL form a 27-bit magnitude: equal signs -> ma+mb, sign=sa; different signs -> larger minus smaller, sign of the larger, with ties resolved as exact zero.
REQ-017 An exact-zero sum SHALL go ADD->DONE with out_result=0x00000000 (+0) and out_zero=1; any other sum SHALL go ADD->NORM.
REQ-018 NORM SHALL perform at most one shift per cycle:
- sum[26]=1: shift right 1, OR the lost bit into bit 0, exp+1.
- otherwise, sum[25]=0: shift left 1, exp-1.
- sum[25]=1 and sum[26]=0: go to ROUND with no shift.
REQ-019 If exp would reach 0 during a left shift, NORM SHALL go to DONE with out_result=sign,0x00,0 and out_zero=1 (no denormals).
REQ-020 ROUND SHALL use round-to-nearest-even: increment fraction [24:2] when bit1=1 and (bit0=1 or bit2=1).
REQ-021 If rounding carries into bit 26, ROUND SHALL shift right 1 and increment exp in the same cycle.
REQ-022 If the final exp is >=255, ROUND SHALL produce out_result=sign,0xFF,0 and out_ovf=1; otherwise out_result=sign,exp[7:0],frac[24:2].
REQ-023 ROUND SHALL always go to DONE.
REQ-024 Latency from the acceptance edge to out_valid=1 SHALL be 3+k cycles, where k is the number of NORM shifts; an exact-zero sum SHALL take 2 cycles.
REQ-025 In DONE, out_valid=1 and out_result and flags SHALL stay stable until a cycle with out_ready=1, after which the next state is IDLE.
REQ-026 in_ready SHALL be 0 in DONE, so accept and release never occur in the same cycle.
REQ-027 out_zero and out_ovf SHALL be mutually exclusive and SHALL be 0 whenever out_valid=0.

Reset
REQ-028 res=1 at a clock edge SHALL force IDLE, out_result=0, out_valid=0, out_zero=0, out_ovf=0 and in_ready=1 after that edge.
REQ-029 Reset SHALL take priority over in_valid and out_ready.
REQ-030 Any in-flight operation SHALL be discarded without producing output.

Verification
REQ-031 in_a=0x2000000, in_b=0x2000000, exp=127 (1.0+1.0) -> out_result=0x40000000, flags 0, out_valid 4 cycles after acceptance.
REQ-032 in_a=0x2000000, in_b=0x6000000, exp=127 (1.0-1.0) -> out_result=0x00000000, out_zero=1, out_valid 2 cycles after acceptance.
REQ-033 in_a=0x3000000, in_b=0x6000000, exp=127 (1.5-1.0) -> one left shift, out_result=0x3F000000, latency 4.
REQ-034 in_a=0x2000000, in_b=0x2000000, exp=254 -> out_result=0x7F800000, out_ovf=1.
REQ-035 Rounding: in_b=0, exp=127.
- in_a=0x2000002 -> out_result=0x3F800000 (tie to even).
- in_a=0x2000006 -> out_result=0x3F800002.
- Both latency 3.
REQ-036 Hold out_ready=0 for 5 cycles in DONE -> result stable and in_ready=0 throughout.
REQ-037 Assert res during NORM -> IDLE next cycle, out_valid never asserted for that operand set.
